// File: rtl/bru_pkg.sv
// Shared constants and helpers for the branch update unit.
// Used by branch_update_unit and pred_meta_fifo.
package bru_pkg;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic int tag_width(input int index_width);
        return 32 - index_width - 2;
    endfunction

endpackage

// File: rtl/pred_meta_fifo.sv
// In-order circular buffer for fetch-time prediction metadata.
// Clear dominates push/pop; a push at full is accepted only with a pop.
module pred_meta_fifo
    import bru_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full_o    = (r_count == CNT_W'(DEPTH));
    assign empty_o   = (r_count == '0);
    assign count_o   = r_count;
    assign data_o    = r_mem[r_rd_ptr];
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);

    // Storage array, written at the tail on an accepted push
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointers and occupancy; reset and clear empty the buffer
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

endmodule

// File: rtl/branch_update_unit.sv
// Commit-side branch resolution: queues IF metadata, detects mispredicts at EX,
// drives the registered EXMEM predictor update bus. Optional: BRU_PERF_CNT_EN.
module branch_update_unit
    import bru_pkg::*;
#(
    parameter int INDEX_WIDTH   = 6,
    parameter int HISTORY_WIDTH = 8,
    parameter int DEPTH         = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                IF_push_i,
    input  logic [31:0]                         IF_pc_i,
    input  logic                                IF_btb_hit_i,
    input  logic                                IF_prediction_i,
    input  logic [31:0]                         IF_btb_rd_target_i,
    input  logic [HISTORY_WIDTH-1:0]            IF_ghr_data_i,
    output logic                                IF_full_o,
    input  logic                                EX_valid_i,
    input  logic                                EX_is_jmp_i,
    input  logic                                EX_br_taken_i,
    input  logic [31:0]                         EX_target_i,
    output logic [INDEX_WIDTH-1:0]              EXMEM_btb_wr_index_o,
    output logic [tag_width(INDEX_WIDTH)-1:0]   EXMEM_btb_wr_tag_o,
    output logic [31:0]                         EXMEM_btb_wr_target_o,
    output logic [HISTORY_WIDTH-1:0]            EXMEM_pht_wr_index_o,
    output logic                                EXMEM_btb_hit_o,
    output logic                                EXMEM_prediction_o,
    output logic                                EXMEM_br_decision_o,
    output logic                                EXMEM_is_jmp_o,
    output logic [HISTORY_WIDTH-1:0]            EXMEM_ghr_data_o,
    output logic                                MEM_flush_o,
    output logic [31:0]                         MEM_redirect_pc_o,
`ifdef BRU_PERF_CNT_EN
    output logic [31:0]                         perf_br_cnt_o,
    output logic [31:0]                         perf_mis_cnt_o,
`endif
    output logic                                err_underflow_o
);

    localparam int TAG_W = tag_width(INDEX_WIDTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0]              pc;
        logic                     btb_hit;
        logic                     prediction;
        logic [31:0]              btb_target;
        logic [HISTORY_WIDTH-1:0] ghr;
    } pred_meta_t;

    localparam int META_W = $bits(pred_meta_t);

    pred_meta_t               w_push_meta;
    pred_meta_t               w_head;
    logic [META_W-1:0]        w_head_bits;
    logic                     w_full;
    logic                     w_empty;
    logic [CNT_W-1:0]         w_count;
    logic                     w_unused;

    logic                     w_push;
    logic                     w_pop_req;
    logic                     w_pop_fire;
    logic                     w_underflow;
    logic                     w_mis;
    logic                     w_clear;
    logic [31:0]              w_pc_next;
    logic [31:0]              w_redirect;

    logic [INDEX_WIDTH-1:0]   r_btb_idx;
    logic [TAG_W-1:0]         r_btb_tag;
    logic [31:0]              r_btb_tgt;
    logic [HISTORY_WIDTH-1:0] r_pht_idx;
    logic                     r_btb_hit;
    logic                     r_pred;
    logic                     r_decision;
    logic                     r_is_jmp;
    logic [HISTORY_WIDTH-1:0] r_ghr;
    logic                     r_flush;
    logic [31:0]              r_redirect;
    logic                     r_err;

    assign w_push_meta = '{
        pc:         IF_pc_i,
        btb_hit:    IF_btb_hit_i,
        prediction: IF_prediction_i,
        btb_target: IF_btb_rd_target_i,
        ghr:        IF_ghr_data_i
    };

    assign w_head = pred_meta_t'(w_head_bits);

    // While the flush pulse is out, fetch is still on the wrong path
    assign w_push      = IF_push_i & ~r_flush;
    assign w_pop_req   = EX_valid_i & ~r_flush;
    assign w_pop_fire  = w_pop_req & ~w_empty;
    assign w_underflow = w_pop_req & w_empty;
    assign w_clear     = w_pop_fire & w_mis;
    assign w_unused    = ^w_count;

    pred_meta_fifo #(
        .WIDTH (META_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (w_clear),
        .push_i  (w_push),
        .pop_i   (w_pop_fire),
        .data_i  (w_push_meta),
        .data_o  (w_head_bits),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    assign IF_full_o = w_full;
    assign w_pc_next = w_head.pc + PC_STEP;

    // Mispredict: wrong direction, wrong taken target, or a BTB alias on a non-branch
    always_comb begin
        w_mis = 1'b0;
        if (EX_is_jmp_i) begin
            w_mis = (w_head.prediction != EX_br_taken_i) |
                    (EX_br_taken_i & w_head.prediction &
                     (w_head.btb_target != EX_target_i));
        end else begin
            w_mis = w_head.prediction;
        end
    end

    assign w_redirect = (EX_is_jmp_i & EX_br_taken_i) ? EX_target_i : w_pc_next;

    // Registered EXMEM update bus and MEM redirect; pulses last one cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_btb_idx  <= '0;
            r_btb_tag  <= '0;
            r_btb_tgt  <= '0;
            r_pht_idx  <= '0;
            r_btb_hit  <= 1'b0;
            r_pred     <= 1'b0;
            r_decision <= 1'b0;
            r_is_jmp   <= 1'b0;
            r_ghr      <= '0;
            r_flush    <= 1'b0;
            r_redirect <= '0;
            r_err      <= 1'b0;
        end else begin
            r_is_jmp <= w_pop_fire & EX_is_jmp_i;
            r_flush  <= w_clear;
            if (w_underflow) begin
                r_err <= 1'b1;
            end
            if (w_pop_fire) begin
                r_btb_idx  <= w_head.pc[INDEX_WIDTH+1:2];
                r_btb_tag  <= w_head.pc[31:INDEX_WIDTH+2];
                r_btb_tgt  <= EX_target_i;
                r_pht_idx  <= w_head.pc[HISTORY_WIDTH+1:2];
                r_btb_hit  <= w_head.btb_hit;
                r_pred     <= w_head.prediction;
                r_decision <= EX_br_taken_i;
                r_ghr      <= w_head.ghr;
                r_redirect <= w_redirect;
            end
        end
    end

    assign EXMEM_btb_wr_index_o  = r_btb_idx;
    assign EXMEM_btb_wr_tag_o    = r_btb_tag;
    assign EXMEM_btb_wr_target_o = r_btb_tgt;
    assign EXMEM_pht_wr_index_o  = r_pht_idx;
    assign EXMEM_btb_hit_o       = r_btb_hit;
    assign EXMEM_prediction_o    = r_pred;
    assign EXMEM_br_decision_o   = r_decision;
    assign EXMEM_is_jmp_o        = r_is_jmp;
    assign EXMEM_ghr_data_o      = r_ghr;
    assign MEM_flush_o           = r_flush;
    assign MEM_redirect_pc_o     = r_redirect;
    assign err_underflow_o       = r_err;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] r_br_cnt;
    logic [31:0] r_mis_cnt;

    // Saturating resolved-branch and mispredict counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_br_cnt  <= '0;
            r_mis_cnt <= '0;
        end else begin
            if (w_pop_fire && EX_is_jmp_i && r_br_cnt != '1) begin
                r_br_cnt <= r_br_cnt + 32'd1;
            end
            if (w_clear && r_mis_cnt != '1) begin
                r_mis_cnt <= r_mis_cnt + 32'd1;
            end
        end
    end

    assign perf_br_cnt_o  = r_br_cnt;
    assign perf_mis_cnt_o = r_mis_cnt;
`endif

endmodule

// File: tb/tb_branch_update_unit.sv
// Directed + randomized bench for branch_update_unit against a queue-based model.
// Compile with BRU_PERF_CNT_EN to also check the perf counters.
module tb_branch_update_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        IF_push_i;
    logic [31:0] IF_pc_i;
    logic        IF_btb_hit_i;
    logic        IF_prediction_i;
    logic [31:0] IF_btb_rd_target_i;
    logic [7:0]  IF_ghr_data_i;
    logic        IF_full_o;
    logic        EX_valid_i;
    logic        EX_is_jmp_i;
    logic        EX_br_taken_i;
    logic [31:0] EX_target_i;
    logic [5:0]  EXMEM_btb_wr_index_o;
    logic [23:0] EXMEM_btb_wr_tag_o;
    logic [31:0] EXMEM_btb_wr_target_o;
    logic [7:0]  EXMEM_pht_wr_index_o;
    logic        EXMEM_btb_hit_o;
    logic        EXMEM_prediction_o;
    logic        EXMEM_br_decision_o;
    logic        EXMEM_is_jmp_o;
    logic [7:0]  EXMEM_ghr_data_o;
    logic        MEM_flush_o;
    logic [31:0] MEM_redirect_pc_o;
    logic        err_underflow_o;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_br_cnt_o;
    logic [31:0] perf_mis_cnt_o;
`endif

    always #5 clk = ~clk;

    branch_update_unit #(
        .INDEX_WIDTH   (6),
        .HISTORY_WIDTH (8),
        .DEPTH         (DEPTH)
    ) dut (
        .clk_i                 (clk),
        .rst_i                 (rst_i),
        .IF_push_i             (IF_push_i),
        .IF_pc_i               (IF_pc_i),
        .IF_btb_hit_i          (IF_btb_hit_i),
        .IF_prediction_i       (IF_prediction_i),
        .IF_btb_rd_target_i    (IF_btb_rd_target_i),
        .IF_ghr_data_i         (IF_ghr_data_i),
        .IF_full_o             (IF_full_o),
        .EX_valid_i            (EX_valid_i),
        .EX_is_jmp_i           (EX_is_jmp_i),
        .EX_br_taken_i         (EX_br_taken_i),
        .EX_target_i           (EX_target_i),
        .EXMEM_btb_wr_index_o  (EXMEM_btb_wr_index_o),
        .EXMEM_btb_wr_tag_o    (EXMEM_btb_wr_tag_o),
        .EXMEM_btb_wr_target_o (EXMEM_btb_wr_target_o),
        .EXMEM_pht_wr_index_o  (EXMEM_pht_wr_index_o),
        .EXMEM_btb_hit_o       (EXMEM_btb_hit_o),
        .EXMEM_prediction_o    (EXMEM_prediction_o),
        .EXMEM_br_decision_o   (EXMEM_br_decision_o),
        .EXMEM_is_jmp_o        (EXMEM_is_jmp_o),
        .EXMEM_ghr_data_o      (EXMEM_ghr_data_o),
        .MEM_flush_o           (MEM_flush_o),
        .MEM_redirect_pc_o     (MEM_redirect_pc_o),
`ifdef BRU_PERF_CNT_EN
        .perf_br_cnt_o         (perf_br_cnt_o),
        .perf_mis_cnt_o        (perf_mis_cnt_o),
`endif
        .err_underflow_o       (err_underflow_o)
    );

    typedef struct {
        bit [31:0] pc;
        bit        hit;
        bit        pred;
        bit [31:0] tgt;
        bit [7:0]  ghr;
    } ent_t;

    ent_t      mq[$];
    bit        m_flush;
    bit [31:0] e_pc, e_tgt, e_redir, e_brc, e_misc;
    bit [7:0]  e_ghr;
    bit        e_hit, e_pred, e_dec, e_jmp, e_flush, e_err;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Next-state of the reference: what the unit should show after this edge
    task automatic model_step();
        ent_t h;
        bit   pop_req, fire, mis, nxt_jmp, nxt_flush;
        if (rst_i) begin
            mq.delete();
            m_flush = 0;
            {e_pc, e_tgt, e_redir, e_brc, e_misc} = '0;
            e_ghr = '0;
            {e_hit, e_pred, e_dec, e_jmp, e_flush, e_err} = '0;
            return;
        end
        pop_req   = EX_valid_i && !m_flush;
        fire      = pop_req && mq.size() > 0;
        nxt_jmp   = 0;
        nxt_flush = 0;
        mis       = 0;
        if (pop_req && mq.size() == 0) e_err = 1;
        if (fire) begin
            h = mq[0];
            if (EX_is_jmp_i)
                mis = (h.pred != EX_br_taken_i) || (EX_br_taken_i && h.tgt != EX_target_i);
            else
                mis = h.pred;
            e_pc    = h.pc;
            e_tgt   = EX_target_i;
            e_hit   = h.hit;
            e_pred  = h.pred;
            e_dec   = EX_br_taken_i;
            e_ghr   = h.ghr;
            e_redir = (EX_is_jmp_i && EX_br_taken_i) ? EX_target_i : h.pc + 32'd4;
            nxt_jmp = EX_is_jmp_i;
            nxt_flush = mis;
            if (EX_is_jmp_i && e_brc != 32'hFFFF_FFFF) e_brc++;
            if (mis && e_misc != 32'hFFFF_FFFF) e_misc++;
        end
        if (fire && mis) begin
            mq.delete();
        end else begin
            if (fire) void'(mq.pop_front());
            if (IF_push_i && !m_flush && mq.size() < DEPTH)
                mq.push_back('{IF_pc_i, IF_btb_hit_i, IF_prediction_i,
                               IF_btb_rd_target_i, IF_ghr_data_i});
        end
        e_jmp   = nxt_jmp;
        e_flush = nxt_flush;
        m_flush = nxt_flush;
    endtask

    task automatic check_all();
        chk("full",    {31'd0, IF_full_o},           {31'd0, mq.size() == DEPTH});
        chk("idx",     {26'd0, EXMEM_btb_wr_index_o}, {26'd0, e_pc[7:2]});
        chk("tag",     {8'd0, EXMEM_btb_wr_tag_o},    {8'd0, e_pc[31:8]});
        chk("tgt",     EXMEM_btb_wr_target_o,         e_tgt);
        chk("pht",     {24'd0, EXMEM_pht_wr_index_o}, {24'd0, e_pc[9:2]});
        chk("hit",     {31'd0, EXMEM_btb_hit_o},      {31'd0, e_hit});
        chk("pred",    {31'd0, EXMEM_prediction_o},   {31'd0, e_pred});
        chk("dec",     {31'd0, EXMEM_br_decision_o},  {31'd0, e_dec});
        chk("is_jmp",  {31'd0, EXMEM_is_jmp_o},       {31'd0, e_jmp});
        chk("ghr",     {24'd0, EXMEM_ghr_data_o},     {24'd0, e_ghr});
        chk("flush",   {31'd0, MEM_flush_o},          {31'd0, e_flush});
        chk("redir",   MEM_redirect_pc_o,             e_redir);
        chk("err",     {31'd0, err_underflow_o},      {31'd0, e_err});
`ifdef BRU_PERF_CNT_EN
        chk("br_cnt",  perf_br_cnt_o,  e_brc);
        chk("mis_cnt", perf_mis_cnt_o, e_misc);
`endif
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        rst_i = 0;
        IF_push_i = 0;
        IF_pc_i = '0;
        IF_btb_hit_i = 0;
        IF_prediction_i = 0;
        IF_btb_rd_target_i = '0;
        IF_ghr_data_i = '0;
        EX_valid_i = 0;
        EX_is_jmp_i = 0;
        EX_br_taken_i = 0;
        EX_target_i = '0;
    endtask

    task automatic push(input logic [31:0] pc, input logic hit, input logic pred,
                        input logic [31:0] tgt, input logic [7:0] ghr);
        IF_push_i = 1;
        IF_pc_i = pc;
        IF_btb_hit_i = hit;
        IF_prediction_i = pred;
        IF_btb_rd_target_i = tgt;
        IF_ghr_data_i = ghr;
    endtask

    task automatic pop(input logic jmp, input logic taken, input logic [31:0] tgt);
        EX_valid_i = 1;
        EX_is_jmp_i = jmp;
        EX_br_taken_i = taken;
        EX_target_i = tgt;
    endtask

    initial begin
        idle();
        rst_i = 1;
        cyc();
        cyc();
        chk("rst_flush", {31'd0, MEM_flush_o}, 32'd0);

        idle(); push(32'h100, 1, 1, 32'h200, 8'h5A); cyc();
        idle(); pop(1, 1, 32'h200); cyc();
        chk("t1_jmp", {31'd0, EXMEM_is_jmp_o}, 32'd1);
        chk("t1_dec", {31'd0, EXMEM_br_decision_o}, 32'd1);
        chk("t1_ghr", {24'd0, EXMEM_ghr_data_o}, 32'h5A);
        chk("t1_idx", {26'd0, EXMEM_btb_wr_index_o}, 32'h00);
        chk("t1_flush", {31'd0, MEM_flush_o}, 32'd0);

        idle(); push(32'h104, 1, 1, 32'h300, 8'h11); cyc();
        idle(); pop(1, 1, 32'h340); cyc();
        chk("t2_flush", {31'd0, MEM_flush_o}, 32'd1);
        chk("t2_redir", MEM_redirect_pc_o, 32'h340);
        idle(); cyc();

        idle(); push(32'h108, 0, 0, 32'h0, 8'h22); cyc();
        idle(); pop(1, 0, 32'h500); cyc();
        chk("t3_flush", {31'd0, MEM_flush_o}, 32'd0);
        chk("t3_hit", {31'd0, EXMEM_btb_hit_o}, 32'd0);
        chk("t3_dec", {31'd0, EXMEM_br_decision_o}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            idle(); push(32'h200 + 32'(4 * i), 0, 0, 32'h0, 8'(i)); cyc();
        end
        chk("t4_full", {31'd0, IF_full_o}, 32'd1);
        idle(); push(32'h210, 0, 0, 32'h0, 8'h44); cyc();
        chk("t4_full_drop", {31'd0, IF_full_o}, 32'd1);
        idle(); push(32'h214, 0, 0, 32'h0, 8'h55); pop(1, 0, 32'h0); cyc();
        chk("t4_full_pp", {31'd0, IF_full_o}, 32'd1);
        chk("t4_head", {26'd0, EXMEM_btb_wr_index_o}, 32'h00);
        for (int i = 0; i < 4; i++) begin
            idle(); pop(1, 0, 32'h0); cyc();
        end
        chk("t4_last", {26'd0, EXMEM_btb_wr_index_o}, 32'h05);

        idle(); push(32'h300, 1, 1, 32'h800, 8'h01); cyc();
        idle(); push(32'h304, 0, 0, 32'h0, 8'h02); cyc();
        idle(); push(32'h308, 0, 0, 32'h0, 8'h03); cyc();
        idle(); push(32'h30C, 0, 0, 32'h0, 8'h04); pop(1, 0, 32'h0); cyc();
        chk("t5_flush", {31'd0, MEM_flush_o}, 32'd1);
        chk("t5_redir", MEM_redirect_pc_o, 32'h304);
        idle(); push(32'h310, 0, 0, 32'h0, 8'h05); pop(1, 0, 32'h0); cyc();
        chk("t5_noerr", {31'd0, err_underflow_o}, 32'd0);
        idle(); push(32'h314, 1, 0, 32'h0, 8'h06); cyc();
        idle(); pop(1, 0, 32'h0); cyc();
        chk("t5_idx", {26'd0, EXMEM_btb_wr_index_o}, 32'h05);
        chk("t5_ghr", {24'd0, EXMEM_ghr_data_o}, 32'h06);

        idle(); pop(1, 1, 32'h0); cyc();
        chk("t6_err", {31'd0, err_underflow_o}, 32'd1);
        chk("t6_nojmp", {31'd0, EXMEM_is_jmp_o}, 32'd0);
        idle(); rst_i = 1; cyc();
        chk("t6_rst_err", {31'd0, err_underflow_o}, 32'd0);
        chk("t6_rst_redir", MEM_redirect_pc_o, 32'd0);

        for (int n = 0; n < 600; n++) begin
            idle();
            rst_i = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) < 6) begin
                push(($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC),
                     1'($urandom), 1'($urandom),
                     32'h1000 + 32'(4 * $urandom_range(0, 3)), 8'($urandom));
            end
            if ($urandom_range(0, 9) < 5) begin
                EX_valid_i = 1;
                EX_is_jmp_i = ($urandom_range(0, 9) < 7);
                EX_br_taken_i = EX_is_jmp_i & 1'($urandom);
                EX_target_i = 32'h1000 + 32'(4 * $urandom_range(0, 3));
                if (mq.size() > 0 && $urandom_range(0, 1) == 1)
                    EX_target_i = mq[0].tgt;
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
